// File: rtl/pe_mac_accum_pkg.sv
// pe_mac_accum_pkg -- shared definitions for the MAC processing element.
//   state_t    : FSM state encoding (IDLE, ACCUM, DRAIN, OUT)
//   DATA_W     : activation operand width
//   COEF_W     : weight operand width
//   PROD_W     : exact signed product width
//   ACC_WIDTH  : accumulator / psum width (equal to the product width)
package pe_mac_accum_pkg;

  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int PROD_W    = DATA_W + COEF_W;
  localparam int ACC_WIDTH = PROD_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/booth_top.sv
// booth_top -- combinational signed 16x16 multiplier, radix-4 Booth recoding.
//   a : signed multiplicand (DATA_W)
//   b : signed multiplier   (COEF_W), recoded in overlapping 3-bit groups
//   p : exact signed product (PROD_W)
// The eight partial products are summed in one expression so synthesis can
// build the carry-save (Wallace) reduction tree.
module booth_top
  import pe_mac_accum_pkg::*;
(
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [COEF_W-1:0] b,
  output logic signed [PROD_W-1:0] p
);

  logic        [COEF_W:0]   b_ext;
  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] pp;
  logic signed [PROD_W-1:0] sum;

  always_comb begin
    b_ext = {b, 1'b0};
    a_ext = {{(PROD_W-DATA_W){a[DATA_W-1]}}, a};
    sum   = '0;
    pp    = '0;
    for (int i = 0; i < COEF_W/2; i++) begin
      // Booth digit in {-2,-1,0,+1,+2} selected by bits b[2i+1], b[2i], b[2i-1]
      unique case (b_ext[2*i +: 3])
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext <<< 1;
        3'b100:         pp = -(a_ext <<< 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      sum = sum + (pp <<< (2*i));
    end
    p = sum;
  end

endmodule

// File: rtl/pe_mac_accum.sv
// pe_mac_accum -- multiply-accumulate processing element producing one psum
// from cfg_len operand beats.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand beat handshake
//   in_act, in_wgt       : signed 16-bit operands
//   psum_in, cfg_len     : initial accumulator and beat count, taken with the
//                          first beat only (cfg_len 0 means 1)
//   out_valid / out_ready: finished psum handshake
//   out_psum             : accumulated psum (wraps modulo 2^ACC_W)
//   busy                 : high whenever the FSM is not IDLE
module pe_mac_accum
  import pe_mac_accum_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int ACC_W = ACC_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DATA_W-1:0] in_act,
  input  logic signed [COEF_W-1:0] in_wgt,
  input  logic signed [ACC_W-1:0]  psum_in,
  input  logic        [LEN_W-1:0]  cfg_len,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0]  out_psum,
  output logic                    busy
);

  function automatic logic signed [ACC_W-1:0] acc_wrap_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    // two's complement wrap, intentionally no saturation
    return a + b;
  endfunction

  state_t                    state;
  logic [LEN_W-1:0]          len;
  logic [LEN_W-1:0]          cnt;
  logic                      accept;
  logic                      out_valid_r;

  logic signed [DATA_W-1:0]  act_p0;
  logic signed [COEF_W-1:0]  wgt_p0;
  logic                      vld_p0;
  logic signed [PROD_W-1:0]  prod_mul;
  logic signed [PROD_W-1:0]  prod_p1;
  logic                      vld_p1;
  logic signed [ACC_W-1:0]   acc_p2;

  assign in_ready  = (state == IDLE) || (state == ACCUM);
  assign accept    = in_valid && in_ready;
  assign busy      = (state != IDLE);
  assign out_valid = out_valid_r;
  assign out_psum  = acc_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      len         <= '0;
      cnt         <= '0;
      out_valid_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            len <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
            cnt <= LEN_W'(1);
            state <= (cfg_len <= LEN_W'(1)) ? DRAIN : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            cnt <= cnt + LEN_W'(1);
            if (cnt + LEN_W'(1) == len) state <= DRAIN;
          end
        end
        DRAIN: begin
          // all beats are in; the last product is the one in p1 with p0 empty
          if (vld_p1 && !vld_p0) begin
            state       <= OUT;
            out_valid_r <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p0: operand register at the accept edge ----
  always_ff @(posedge clk) begin
    if (accept) begin
      act_p0 <= in_act;
      wgt_p0 <= in_wgt;
    end
  end

  booth_top u_mult (
    .a (act_p0),
    .b (wgt_p0),
    .p (prod_mul)
  );

  // ---- stage p1: product register ----
  always_ff @(posedge clk) begin
    prod_p1 <= prod_mul;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= accept;
      vld_p1 <= vld_p0;
    end
  end

  // ---- stage p2: accumulator, seeded by psum_in on the first beat ----
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p2 <= '0;
    end else if (state == IDLE && accept) begin
      acc_p2 <= psum_in;
    end else if (vld_p1) begin
      acc_p2 <= acc_wrap_add(acc_p2, prod_p1);
    end
  end

endmodule

// File: tb/tb_pe_mac_accum.sv
module tb_pe_mac_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_act;
  logic [15:0] in_wgt;
  logic [31:0] psum_in;
  logic [7:0]  cfg_len;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_psum;
  logic        busy;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic [15:0] cur_act [8];
  logic [15:0] cur_wgt [8];

  pe_mac_accum dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_act    (in_act),
    .in_wgt    (in_wgt),
    .psum_in   (psum_in),
    .cfg_len   (cfg_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_psum  (out_psum),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0]       psum;
    logic [7:0]        clen;
    logic [3:0]        nb;
    logic [3:0][15:0]  act;
    logic [3:0][15:0]  wgt;
    logic [3:0]        gap;
    logic [3:0]        hold;
    logic [31:0]       exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  // Reference: psum_in plus the sum of exact products, reduced modulo 2^32.
  function automatic logic [31:0] model(input logic [31:0] psum, input int nb);
    longint s;
    s = longint'($signed(psum));
    for (int i = 0; i < nb; i++)
      s = s + longint'($signed(cur_act[i])) * longint'($signed(cur_wgt[i]));
    return s[31:0];
  endfunction

  task automatic garbage();
    in_act  = 16'($urandom);
    in_wgt  = 16'($urandom);
    psum_in = $urandom;
    cfg_len = 8'($urandom);
  endtask

  // Caller is at a negedge. Sends nb beats, waits for the psum, holds
  // out_ready low for 'hold' cycles, then transfers.
  task automatic run_txn(input string nm, input logic [31:0] psum, input logic [7:0] clen,
                         input int nb, input int gap, input int hold, input logic [31:0] exp);
    int n;
    int acc_cyc;
    acc_cyc = 0;
    for (int b = 0; b < nb; b++) begin
      if (b > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          garbage();
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_act   = cur_act[b];
      in_wgt   = cur_wgt[b];
      psum_in  = (b == 0) ? psum : $urandom;
      cfg_len  = (b == 0) ? clen : 8'($urandom);
      n = 0;
      while (!in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        chk({nm, "_accept_timeout"}, 0, 1);
        in_valid = 1'b0;
        return;
      end
      acc_cyc = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
    garbage();
    n = 0;
    while (!out_valid && n < 20) begin
      chk({nm, "_drain_ready"}, in_ready, 0);
      chk({nm, "_drain_busy"}, busy, 1);
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk({nm, "_out_timeout"}, 0, 1);
      return;
    end
    chk({nm, "_latency"}, cyc - acc_cyc, 3);
    chk({nm, "_psum"}, out_psum, exp);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      garbage();
      @(negedge clk);
      chk({nm, "_hold_valid"}, out_valid, 1);
      chk({nm, "_hold_psum"}, out_psum, exp);
      chk({nm, "_hold_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_post_valid"}, out_valid, 0);
    chk({nm, "_post_busy"}, busy, 0);
    chk({nm, "_post_ready"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_act = '0; in_wgt = '0; psum_in = '0; cfg_len = '0;

    vecs[0] = '{psum: 32'd10, clen: 8'd1, nb: 4'd1, act: {16'd0, 16'd0, 16'd0, 16'd3},
                wgt: {16'd0, 16'd0, 16'd0, 16'hFFFE}, gap: 4'd0, hold: 4'd0, exp: 32'd4};
    vecs[1] = '{psum: 32'd0, clen: 8'd4, nb: 4'd4, act: {16'd4, 16'd3, 16'd2, 16'd1},
                wgt: {16'd2, 16'd2, 16'd2, 16'd2}, gap: 4'd0, hold: 4'd0, exp: 32'd20};
    vecs[2] = '{psum: 32'd0, clen: 8'd3, nb: 4'd3, act: {16'd0, 16'h8000, 16'h8000, 16'h8000},
                wgt: {16'd0, 16'h8000, 16'h8000, 16'h8000}, gap: 4'd2, hold: 4'd0, exp: 32'hC0000000};
    vecs[3] = '{psum: 32'd0, clen: 8'd3, nb: 4'd3, act: {16'd0, 16'h8000, 16'h8000, 16'h8000},
                wgt: {16'd0, 16'h8000, 16'h8000, 16'h8000}, gap: 4'd2, hold: 4'd5, exp: 32'hC0000000};
    vecs[4] = '{psum: 32'h7FFFFFFF, clen: 8'd1, nb: 4'd1, act: {16'd0, 16'd0, 16'd0, 16'd1},
                wgt: {16'd0, 16'd0, 16'd0, 16'd1}, gap: 4'd0, hold: 4'd0, exp: 32'h80000000};
    vecs[5] = '{psum: 32'd100, clen: 8'd0, nb: 4'd1, act: {16'd0, 16'd0, 16'd0, 16'd7},
                wgt: {16'd0, 16'd0, 16'd0, 16'hFFFD}, gap: 4'd0, hold: 4'd1, exp: 32'd79};
    vecs[6] = '{psum: 32'd0, clen: 8'd2, nb: 4'd2, act: {16'd0, 16'd0, 16'd1, 16'd5},
                wgt: {16'd0, 16'd0, 16'd1, 16'd5}, gap: 4'd0, hold: 4'd0, exp: 32'd26};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_psum", out_psum, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      for (int b = 0; b < 4; b++) begin
        cur_act[b] = vecs[v].act[b];
        cur_wgt[b] = vecs[v].wgt[b];
      end
      run_txn($sformatf("vec%0d", v), vecs[v].psum, vecs[v].clen, int'(vecs[v].nb),
              int'(vecs[v].gap), int'(vecs[v].hold), vecs[v].exp);
      @(negedge clk);
    end

    // Reset in ACCUM after two of four beats discards the partial psum.
    in_valid = 1'b1; in_act = 16'd2; in_wgt = 16'd3; psum_in = 32'd555; cfg_len = 8'd4;
    @(negedge clk);
    in_act = 16'd4; in_wgt = 16'd5;
    @(negedge clk);
    chk("mid_busy", busy, 1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_psum", out_psum, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_rst_no_out", out_valid, 0);
    end
    for (int b = 0; b < 4; b++) begin
      cur_act[b] = vecs[6].act[b];
      cur_wgt[b] = vecs[6].wgt[b];
    end
    run_txn("after_rst", vecs[6].psum, vecs[6].clen, int'(vecs[6].nb), 0, 0, vecs[6].exp);
    @(negedge clk);

    for (int t = 0; t < 20; t++) begin
      int nb;
      logic [7:0] clen;
      logic [31:0] ps;
      nb = $urandom_range(1, 6);
      clen = 8'(nb);
      if (t % 5 == 0) begin
        nb = 1;
        clen = 8'd0;
      end
      ps = $urandom;
      for (int b = 0; b < nb; b++) begin
        cur_act[b] = 16'($urandom);
        cur_wgt[b] = 16'($urandom);
      end
      run_txn($sformatf("rnd%0d", t), ps, clen, nb, $urandom_range(0, 2),
              $urandom_range(0, 3), model(ps, nb));
      if (t % 3 == 0) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_mac_accum.md
PE_MAC_ACCUM -- requirements
Module: pe_mac_accum

Interface
REQ-001 SHALL have parameter LEN_W, default 8, width of the per-psum MAC count.
REQ-002 SHALL have parameter ACC_W, default 32, the accumulator and psum width, fixed equal to the multiplier product width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand beat valid.
REQ-006 in_ready  output  1  block can accept an operand beat.
REQ-007 in_act  input  16  signed activation operand.
REQ-008 in_wgt  input  16  signed weight operand.
REQ-009 psum_in  input  ACC_W  initial accumulator value, sampled only with the first beat of a psum.
REQ-010 cfg_len  input  LEN_W  number of beats per psum, sampled only with the first beat; value 0 is treated as 1.
REQ-011 out_valid  output  1  finished psum available.
REQ-012 out_ready  input  1  downstream accepts the psum.
REQ-013 out_psum  output  ACC_W  accumulated signed psum.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 A beat SHALL be accepted on a rising edge where in_valid and in_ready are both high; an out transfer SHALL occur where out_valid and out_ready are both high.
REQ-016 The FSM SHALL have states IDLE, ACCUM, DRAIN and OUT.
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in DRAIN and OUT.
REQ-018 IDLE, on accept: latch len (0 becomes 1), load acc with psum_in, set cnt to 1, register the operands; go to DRAIN if len==1, else to ACCUM.
REQ-019 ACCUM, on accept: register the operands and increment cnt; go to DRAIN when the accepted beat makes cnt==len.
REQ-020 ACCUM without accept: hold state and cnt; input bubbles of any length SHALL be tolerated.
REQ-021 Pipeline: operand register at the accept edge, E0; product register at E1 holds signed in_act*in_wgt (32 bits, exact); acc += product at E2; each stage carries a valid bit.
REQ-022 DRAIN SHALL go to OUT on the edge at which the last product is added to acc.
REQ-023 out_valid SHALL rise in cycle c+3 when the last beat is accepted in cycle c.
REQ-024 OUT: out_valid=1 and out_psum=acc, both held stable while out_ready=0; on transfer go to IDLE, with out_valid=0 in the next cycle.
REQ-025 No beat SHALL be accepted in the transfer cycle; the earliest next first-beat accept is the following cycle.
REQ-026 Accumulation SHALL be two's complement modulo 2^ACC_W, with no saturation and no overflow flag.
REQ-027 in_act, in_wgt, psum_in and cfg_len SHALL be ignored when no accept occurs.

Reset
REQ-028 While rst=1 at an edge: state is IDLE, cnt=0, len=0, acc=0, and all pipeline valid bits are 0.
REQ-029 Reset values SHALL be out_valid=0, out_psum=0, busy=0, and in_ready=1 from the first cycle after rst deasserts.
REQ-030 Reset in any state SHALL discard in-flight beats and any partial psum; no out transfer SHALL follow from them.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (IDLE, ACCUM, DRAIN, OUT) and the ACC_W and operand width constants.
REQ-032 The multiply SHALL be one instance of the team's 16x16 Booth/Wallace multiplier, booth_top, placed combinationally between the operand and product registers.
REQ-033 booth_top SHALL be the only sub-module; FSM, counter, pipeline and accumulator SHALL live in pe_mac_accum.

Verification
REQ-034 len=1, act=3, wgt=0xFFFE (-2), psum_in=10 -> out_psum=4, with out_valid rising exactly 3 cycles after the accept.
REQ-035 len=4, acts 1,2,3,4, wgt=2 each, psum_in=0, back-to-back -> out_psum=20, and in_ready=0 from the cycle after the 4th accept until return to IDLE.
REQ-036 len=3 with 2-cycle in_valid bubbles, act=-32768, wgt=-32768 each -> out_psum=0x40000000*3 mod 2^32 = 0xC0000000.
REQ-037 Same transaction, out_ready low 5 cycles -> out_psum stable and in_valid ignored throughout; on release, transfer occurs and IDLE follows next cycle.
REQ-038 psum_in=0x7FFFFFFF, len=1, act=1, wgt=1 -> out_psum=0x80000000 (wrap); cfg_len=0 -> behaves as len=1.
REQ-039 rst pulsed in ACCUM after 2 of 4 beats -> outputs at reset values next cycle, no out_valid; a new len=2 transaction (5*5, 1*1, psum_in=0) -> 26.
